id_ex_stage: RTL and testbench

Pipeline register and operand-select stage directly upstream of the ALU in the pipelined core. It latches decoded instruction fields from the ID stage and drives the ALU's `x`, `y`, `shamt` and `ALUout` inputs. Operands are forwarded from the two downstream stages, and the stage detects load-use hazards. It supports a hold on `stall` and a bubble on `flush`.

---
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// load-use hazard detection, stall hold and flush/bubble insertion.
module id_ex_stage #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [W-1:0] id_rs_data,
  input  logic [W-1:0] id_rt_data,
  input  logic [W-1:0] id_imm,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [4:0]   id_rd,
  input  logic [4:0]   id_shamt,
  input  logic [3:0]   id_alu_ctrl,
  input  logic         id_alu_src,
  input  logic         id_uses_rt,
  input  logic         id_reg_write,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         mem_reg_write,
  input  logic [4:0]   mem_rd,
  input  logic [W-1:0] mem_result,
  input  logic         wb_reg_write,
  input  logic [4:0]   wb_rd,
  input  logic [W-1:0] wb_result,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [4:0]   shamt,
  output logic [3:0]   ALUout,
  output logic         ex_valid,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic [4:0]   ex_rd,
  output logic [W-1:0] ex_store_data,
  output logic         hazard_stall
);

  typedef struct packed {
    logic         valid;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         alu_src;
    logic [4:0]   rd;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   shamt;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic [W-1:0] imm;
  } ex_regs_t;

  ex_regs_t ex_q, ex_d, id_load;
  logic [W-1:0] fx, frt;

  always_comb begin
    id_load           = '0;
    id_load.valid     = id_valid;
    id_load.reg_write = id_valid & id_reg_write;
    id_load.mem_read  = id_valid & id_mem_read;
    id_load.mem_write = id_valid & id_mem_write;
    id_load.alu_src   = id_alu_src;
    id_load.rd        = id_rd;
    id_load.rs        = id_rs;
    id_load.rt        = id_rt;
    id_load.shamt     = id_shamt;
    id_load.alu_ctrl  = id_alu_ctrl;
    id_load.rs_data   = id_rs_data;
    id_load.rt_data   = id_rt_data;
    id_load.imm       = id_imm;
  end

  // Driven from the current EX contents even when a flush is pending.
  always_comb begin
    hazard_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                   ((ex_q.rd == id_rs) | (id_uses_rt & (ex_q.rd == id_rt)));
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (hazard_stall) begin
      ex_d = '0;
    end else begin
      ex_d = id_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // EX/MEM beats MEM/WB; r0 never forwarded.
  always_comb begin
    fx = ex_q.rs_data;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_q.rs)) begin
      fx = mem_result;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_q.rs)) begin
      fx = wb_result;
    end
  end

  always_comb begin
    frt = ex_q.rt_data;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_q.rt)) begin
      frt = mem_result;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_q.rt)) begin
      frt = wb_result;
    end
  end

  always_comb begin
    x             = fx;
    y             = ex_q.alu_src ? ex_q.imm : frt;
    ex_store_data = frt;
    shamt         = ex_q.shamt;
    ALUout        = ex_q.alu_ctrl;
    ex_valid      = ex_q.valid;
    ex_reg_write  = ex_q.reg_write;
    ex_mem_read   = ex_q.mem_read;
    ex_mem_write  = ex_q.mem_write;
    ex_rd         = ex_q.rd;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a record-level model of "the instruction
// sitting in EX" predicts every cycle's outputs; a monitor compares at negedge.
module tb_id_ex_stage;

  typedef struct {
    bit          rst, stall, flush, valid;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd, sh;
    logic [3:0]  alu;
    bit          src, urt, rw, mr, mw;
    bit          mrw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    bit          wrw;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } in_t;

  typedef struct {
    logic [31:0] x, y, st;
    logic [4:0]  sh, rd;
    logic [3:0]  alu;
    logic        v, rw, mr, mw, hz;
  } exp_t;

  logic        clk = 0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic [31:0] x, y, ex_store_data;
  logic [4:0]  shamt, ex_rd;
  logic [3:0]  ALUout;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall;

  id_ex_stage #(.W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .x(x), .y(y), .shamt(shamt), .ALUout(ALUout), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  in_t  cur;
  in_t  exr;          // instruction occupying EX; all-zero record means a bubble
  logic [3:0] codes [11] = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h6, 4'hE, 4'h5, 4'hC, 4'h7, 4'h8, 4'hF};

  task automatic drive(input in_t i);
    rst = i.rst; stall = i.stall; flush = i.flush; id_valid = i.valid;
    id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_shamt = i.sh;
    id_alu_ctrl = i.alu; id_alu_src = i.src; id_uses_rt = i.urt;
    id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw;
    mem_reg_write = i.mrw; mem_rd = i.mrd; mem_result = i.mres;
    wb_reg_write = i.wrw; wb_rd = i.wrd; wb_result = i.wres;
  endtask

  function automatic in_t empty_in();
    in_t e;
    e = '{default: 0};
    return e;
  endfunction

  // Newest producer first; r0 is hardwired and never supplied by a producer.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regfile_val,
                                          input in_t i);
    bit          we  [2];
    logic [4:0]  dst [2];
    logic [31:0] val [2];
    we[0] = i.mrw; dst[0] = i.mrd; val[0] = i.mres;
    we[1] = i.wrw; dst[1] = i.wrd; val[1] = i.wres;
    if (idx == 0) return regfile_val;
    for (int k = 0; k < 2; k++)
      if (we[k] && dst[k] == idx) return val[k];
    return regfile_val;
  endfunction

  function automatic bit load_use(input in_t e, input in_t i);
    bit ex_is_load;
    ex_is_load = e.valid && e.mr && (e.rd != 0);
    return ex_is_load && i.valid && (e.rd == i.rs || (i.urt && e.rd == i.rt));
  endfunction

  function automatic exp_t predict(input in_t e, input in_t i);
    exp_t p;
    logic [31:0] b;
    b    = operand(e.rt, e.rtd, i);
    p.x  = operand(e.rs, e.rsd, i);
    p.y  = e.src ? e.imm : b;
    p.st = b;
    p.sh = e.sh; p.rd = e.rd; p.alu = e.alu;
    p.v  = e.valid;
    p.rw = e.valid && e.rw;
    p.mr = e.valid && e.mr;
    p.mw = e.valid && e.mw;
    p.hz = load_use(e, i);
    return p;
  endfunction

  // One clock: the edge consumes the inputs of the cycle just ended, then nin is applied.
  task automatic step(input in_t nin);
    @(posedge clk);
    if (cur.rst || cur.flush)        exr = empty_in();
    else if (cur.stall)              exr = exr;
    else if (load_use(exr, cur))     exr = empty_in();
    else                             exr = cur;
    #1;
    cur = nin;
    drive(cur);
    sb.push_back(predict(exr, cur));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("x", x, e.x);
        chk("y", y, e.y);
        chk("store_data", ex_store_data, e.st);
        chk("shamt", {27'd0, shamt}, {27'd0, e.sh});
        chk("ALUout", {28'd0, ALUout}, {28'd0, e.alu});
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
        chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, e.mw});
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.hz});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic in_t rand_in();
    in_t r;
    r.rst   = ($urandom_range(0, 49) == 0);
    r.flush = ($urandom_range(0, 11) == 0);
    r.stall = ($urandom_range(0, 5) == 0);
    r.valid = ($urandom_range(0, 7) != 0);
    r.rsd = $urandom; r.rtd = $urandom; r.imm = $urandom;
    r.rs = 5'($urandom_range(0, 7)); r.rt = 5'($urandom_range(0, 7));
    r.rd = 5'($urandom_range(0, 7)); r.sh = 5'($urandom);
    r.alu = codes[$urandom_range(0, 10)];
    r.src = $urandom_range(0, 1); r.urt = $urandom_range(0, 1);
    r.rw  = $urandom_range(0, 1); r.mr = ($urandom_range(0, 2) == 0);
    r.mw  = ($urandom_range(0, 3) == 0);
    r.mrw = $urandom_range(0, 1); r.mrd = 5'($urandom_range(0, 7)); r.mres = $urandom;
    r.wrw = $urandom_range(0, 1); r.wrd = 5'($urandom_range(0, 7)); r.wres = $urandom;
    return r;
  endfunction

  initial begin : stimulus
    in_t n;
    in_t f;
    exr = empty_in();
    // Reset held two cycles with every ID field nonzero.
    cur = '{rst: 1, valid: 1, rsd: 32'hA5A5A5A5, rtd: 32'h5A5A5A5A, imm: 32'h1234,
            rs: 5'd3, rt: 5'd4, rd: 5'd5, sh: 5'd7, alu: 4'h2, src: 1, urt: 1,
            rw: 1, mr: 1, mw: 1, default: 0};
    drive(cur);
    step(cur);
    step(cur);

    // ADD with a negative rs operand.
    n = empty_in();
    n.valid = 1; n.rsd = 32'hFFFFFFFC; n.rtd = 32'h3; n.alu = 4'h2;
    n.rs = 5'd1; n.rt = 5'd2; n.rd = 5'd3; n.rw = 1;
    step(n);

    // Forwarding priority on rs=5, held in EX by stall.
    n = empty_in();
    n.valid = 1; n.rs = 5'd5; n.rt = 5'd6; n.rsd = 32'hAAAA0000; n.rtd = 32'h0000BBBB;
    n.alu = 4'h0; n.rd = 5'd7; n.rw = 1;
    step(n);
    f = n; f.stall = 1;
    f.mrw = 1; f.mrd = 5'd5; f.mres = 32'h11111111;
    f.wrw = 1; f.wrd = 5'd5; f.wres = 32'h22222222;
    step(f);
    f.mrw = 0;
    step(f);

    // r0 source with a matching EX/MEM write to r0.
    n = empty_in();
    n.valid = 1; n.rs = 5'd0; n.rsd = 32'h12345678; n.rtd = 32'h9; n.alu = 4'h1;
    step(n);
    f = n; f.stall = 1; f.mrw = 1; f.mrd = 5'd0; f.mres = 32'hDEADBEEF;
    step(f);

    // Load to r8 followed by a reader of r8.
    n = empty_in();
    n.valid = 1; n.mr = 1; n.rw = 1; n.rd = 5'd8; n.rs = 5'd1; n.alu = 4'h2;
    n.src = 1; n.imm = 32'h10;
    step(n);
    n = empty_in();
    n.valid = 1; n.rs = 5'd8; n.rt = 5'd2; n.rd = 5'd9; n.rw = 1; n.alu = 4'h2;
    n.rsd = 32'h77; n.rtd = 32'h88;
    step(n);
    step(n);
    step(n);
    step(n);

    // Stall for three cycles with changing ID inputs, then stall+flush together.
    for (int unsigned i = 0; i < 3; i++) begin
      n = rand_in();
      n.rst = 0; n.flush = 0; n.stall = 1;
      step(n);
    end
    n = rand_in();
    n.rst = 0; n.stall = 1; n.flush = 1;
    step(n);
    n = rand_in();
    n.rst = 0; n.stall = 0; n.flush = 0;
    step(n);

    for (int unsigned i = 0; i < 400; i++) step(rand_in());

    step(empty_in());
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
